// File: rtl/request_serializer_pkg.sv
// Shared types and derivation helpers for the request serializer.
package request_serializer_pkg;

    // Serializer FSM: IDLE waits for a request, SEND walks its beats out.
    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;

    // Number of beats per request; 0 flags an unusable width pair.
    function automatic int unsigned calc_num_beats(input int unsigned req_width,
                                                   input int unsigned beat_width);
        if (beat_width == 0) begin
            return 0;
        end
        return req_width / beat_width;
    endfunction

    // Beat counter width, never narrower than one bit.
    function automatic int unsigned calc_num_beats_log2(input int unsigned num_beats);
        if (num_beats <= 2) begin
            return 1;
        end
        return $clog2(num_beats);
    endfunction

endpackage

// File: rtl/request_serializer.sv
// Splits one wide arbitrated request into NUM_BEATS narrow beats, LSB beat first.
module request_serializer
    import request_serializer_pkg::*;
#(
    parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
    parameter int unsigned BEAT_WIDTH_IN_BITS           = 16,
    localparam int unsigned NUM_BEATS      =
        calc_num_beats(SINGLE_REQUEST_WIDTH_IN_BITS, BEAT_WIDTH_IN_BITS),
    localparam int unsigned NUM_BEATS_LOG2 = calc_num_beats_log2(NUM_BEATS)
) (
    input  logic                                    clk_in,
    input  logic                                    reset_in,
    input  logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_in,
    input  logic                                    request_valid_in,
    output logic                                    issue_ack_out,
    output logic [BEAT_WIDTH_IN_BITS-1:0]           beat_out,
    output logic                                    beat_valid_out,
    output logic                                    beat_last_out,
    output logic [NUM_BEATS_LOG2-1:0]               beat_index_out,
    input  logic                                    issue_ack_in,
    output logic                                    busy_out
);

    localparam logic [NUM_BEATS_LOG2-1:0] LAST_INDEX = NUM_BEATS_LOG2'(NUM_BEATS - 1);

    // Reject width pairs that cannot be split into whole beats.
    if (BEAT_WIDTH_IN_BITS == 0 ||
        BEAT_WIDTH_IN_BITS > SINGLE_REQUEST_WIDTH_IN_BITS ||
        (SINGLE_REQUEST_WIDTH_IN_BITS % BEAT_WIDTH_IN_BITS) != 0) begin : g_bad_width
        $error("request_serializer: request width must be a whole multiple of beat width");
    end

    state_e                                  state_q, state_d;
    logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0] shift_q, shift_d;
    logic [NUM_BEATS_LOG2-1:0]               count_q, count_d;
    logic                                    last_q, last_d;

    // Accept a new request when idle, or in the same edge the final beat drains.
    always_comb begin
        issue_ack_out = 1'b0;
        if (!reset_in) begin
            issue_ack_out = (state_q == StIdle) ||
                            ((state_q == StSend) && last_q && issue_ack_in);
        end
    end

    // Next-state logic: load, shift, or drain back to idle.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        unique case (state_q)
            StIdle: begin
                if (request_valid_in) begin
                    shift_d = request_in;
                    count_d = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (issue_ack_in) begin
                    if (!last_q) begin
                        shift_d = shift_q >> BEAT_WIDTH_IN_BITS;
                        count_d = count_q + 1'b1;
                    end else if (request_valid_in) begin
                        shift_d = request_in;
                        count_d = '0;
                    end else begin
                        shift_d = '0;
                        count_d = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so beat_last_out comes straight off a flop.
        last_d = (state_d == StSend) && (count_d == LAST_INDEX);
    end

    // State registers with synchronous reset discarding any held request.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q <= StIdle;
            shift_q <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    assign beat_out       = shift_q[BEAT_WIDTH_IN_BITS-1:0];
    assign beat_valid_out = (state_q == StSend);
    assign beat_last_out  = last_q;
    assign beat_index_out = count_q;
    assign busy_out       = (state_q == StSend);

endmodule
